// File: rtl/mem_word_master.sv
// Word-to-byte RAM initiator: turns one word request into WORD_BYTES
// sequential byte accesses. It assembles read bytes into a word, or splits a
// write word into bytes. Byte 0 sits at the lowest address.
module mem_word_master #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned RAM_ADDR_BITS = 8,
  parameter int unsigned WORD_BYTES    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req,
  input  logic                          we,
  input  logic [RAM_ADDR_BITS-1:0]      addr,
  input  logic [WIDTH*WORD_BYTES-1:0]   wdata,
  output logic                          busy,
  output logic                          done,
  output logic [WIDTH*WORD_BYTES-1:0]   rdata,
  output logic                          mem_en,
  output logic                          mem_write,
  output logic [RAM_ADDR_BITS-1:0]      mem_adr,
  output logic [WIDTH-1:0]              mem_wdata,
  input  logic [WIDTH-1:0]              mem_rdata
);

  localparam int unsigned WordW = WIDTH * WORD_BYTES;
  localparam int unsigned CntW  = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     we_q, we_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [WordW-1:0]         wdata_q, wdata_d;
  logic [WordW-1:0]         shadow_q, shadow_d;
  logic [WordW-1:0]         rdata_q, rdata_d;

  // Next-state: accept a request in idle, step through the bytes, then pulse done.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        // The RAM registered this byte on the negedge, so it is valid at this edge.
        if (!we_q) begin
          shadow_d[WIDTH*cnt_q +: WIDTH] = mem_rdata;
        end
        if (cnt_q == CntW'(WORD_BYTES - 1)) begin
          state_d = StDone;
          // Publish the word (including the byte just captured) as done rises.
          if (!we_q) begin
            rdata_d = shadow_d;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset; reset abandons any partial transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs from registered state only. The address and data buses keep their
  // last values outside ACCESS because addr_q, cnt_q and wdata_q are held there.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    mem_en    = (state_q == StAccess);
    mem_write = (state_q == StAccess) && we_q;
    mem_adr   = addr_q + RAM_ADDR_BITS'(cnt_q);
    mem_wdata = wdata_q[WIDTH*cnt_q +: WIDTH];
    rdata     = rdata_q;
  end

endmodule

// File: tb/tb_mem_word_master.sv
// Self-checking bench for mem_word_master: a byte RAM responder plus a
// word-level reference memory and expected read word.
module tb_mem_word_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        mem_en;
  logic        mem_write;
  logic [7:0]  mem_adr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram       [256];
  logic [7:0]  model_mem [256];
  logic [31:0] rdata_exp;
  int          n_checks = 0;
  int          n_errors = 0;

  mem_word_master #(
    .WIDTH        (8),
    .RAM_ADDR_BITS(8),
    .WORD_BYTES   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .mem_en   (mem_en),
    .mem_write(mem_write),
    .mem_adr  (mem_adr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte-wide RAM acting on the negedge
  always @(negedge clk) begin
    if (mem_en) begin
      if (mem_write) ram[mem_adr] <= mem_wdata;
      else           mem_rdata    <= ram[mem_adr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [31:0] w;
    logic [7:0]  idx;
    for (int i = 0; i < 4; i++) begin
      idx = a + 8'(i);
      w[8*i +: 8] = model_mem[idx];
    end
    return w;
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [31:0] d);
    logic [7:0] idx;
    for (int i = 0; i < 4; i++) begin
      idx = a + 8'(i);
      model_mem[idx] = d[8*i +: 8];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one single-cycle request from IDLE and check the full transaction.
  task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d);
    logic [7:0] ea;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    step();
    // Scramble inputs while busy; the latched copies must be used.
    req   = 1'b0;
    we    = 1'($urandom);
    addr  = 8'($urandom);
    wdata = $urandom;
    for (int i = 0; i < 4; i++) begin
      ea = a + 8'(i);
      check("mem_en", mem_en, 1);
      check("mem_write", mem_write, w);
      check("mem_adr", mem_adr, ea);
      if (w) check("mem_wdata", mem_wdata, d[8*i +: 8]);
      check("busy_access", busy, 1);
      check("done_early", done, 0);
      step();
    end
    if (w) model_write(a, d);
    else   rdata_exp = model_read(a);
    check("done_pulse", done, 1);
    check("mem_en_done", mem_en, 0);
    check("mem_write_done", mem_write, 0);
    check("busy_done", busy, 1);
    check("rdata_done", rdata, rdata_exp);
    step();
    check("busy_idle", busy, 0);
    check("done_idle", done, 0);
    check("rdata_hold", rdata, rdata_exp);
  endtask

  initial begin
    logic [7:0] adr_q[$];
    logic [7:0] exp_adr[$];
    int         dones;
    int         overlap;
    int         bad;
    logic       rw;
    logic [7:0] ra;

    reset = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    rdata_exp = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i]       = 8'($urandom);
      model_mem[i] = ram[i];
    end
    ram[8'h10] = 8'h11; ram[8'h11] = 8'h22; ram[8'h12] = 8'h33; ram[8'h13] = 8'h44;
    model_mem[8'h10] = 8'h11; model_mem[8'h11] = 8'h22;
    model_mem[8'h12] = 8'h33; model_mem[8'h13] = 8'h44;

    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_adr", mem_adr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b0;
    step();

    // Basic read
    xfer(1'b0, 8'h10, 32'h0);
    check("t1_rdata", rdata, 32'h44332211);

    // Write then read back
    xfer(1'b1, 8'h20, 32'hDEADBEEF);
    check("t2_rdata_kept", rdata, 32'h44332211);
    xfer(1'b0, 8'h20, 32'h0);
    check("t2_readback", rdata, 32'hDEADBEEF);

    // Address wrap
    xfer(1'b1, 8'hFE, 32'h01020304);
    xfer(1'b0, 8'hFE, 32'h0);
    check("t3_readback", rdata, 32'h01020304);
    check("t3_ram_fe", ram[8'hFE], 8'h04);
    check("t3_ram_01", ram[8'h01], 8'h01);

    // req held high, addr changed mid-transfer
    req   = 1'b1;
    we    = 1'b0;
    addr  = 8'h50;
    dones = 0;
    overlap = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 2) addr = 8'h30;
      if (k == 12) req = 1'b0;
      if (mem_en) adr_q.push_back(mem_adr);
      if (done) dones++;
      if (mem_en && done) overlap++;
    end
    exp_adr = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h30, 8'h31, 8'h32, 8'h33};
    check("t4_n_bytes", adr_q.size(), exp_adr.size());
    for (int i = 0; i < exp_adr.size() && i < adr_q.size(); i++) begin
      check("t4_adr", adr_q[i], exp_adr[i]);
    end
    check("t4_dones", dones, 2);
    check("t4_overlap", overlap, 0);
    rdata_exp = model_read(8'h30);
    check("t4_rdata", rdata, rdata_exp);
    check("t4_busy_end", busy, 0);

    // Reset during the third byte of a write
    req   = 1'b1;
    we    = 1'b1;
    addr  = 8'h40;
    wdata = 32'hAABBCCDD;
    step();
    req = 1'b0;
    step();
    step();
    check("t5_third_adr", mem_adr, 8'h42);
    reset = 1'b1;
    step();
    model_mem[8'h40] = 8'hDD;
    model_mem[8'h41] = 8'hCC;
    model_mem[8'h42] = 8'hBB;
    rdata_exp = '0;
    check("t5_mem_en", mem_en, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_rdata", rdata, 0);
    check("t5_mem_adr", mem_adr, 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_no_done", done, 0);
      check("t5_idle", busy, 0);
    end
    check("t5_ram_40", ram[8'h40], 8'hDD);
    check("t5_ram_41", ram[8'h41], 8'hCC);
    check("t5_ram_43", ram[8'h43], model_mem[8'h43]);

    // reset and req together: reset wins
    reset = 1'b1;
    req   = 1'b1;
    we    = 1'b0;
    addr  = 8'h10;
    step();
    check("t6_busy", busy, 0);
    check("t6_mem_en", mem_en, 0);
    reset = 1'b0;
    xfer(1'b0, 8'h10, 32'h0);
    check("t6_rdata", rdata, 32'h44332211);

    // Randomized transfers, biased toward the wrap region
    for (int n = 0; n < 40; n++) begin
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) ra = 8'hFC + 8'($urandom_range(0, 3));
      else                           ra = 8'($urandom);
      xfer(rw, ra, $urandom);
      repeat ($urandom_range(0, 2)) begin
        step();
        check("rand_gap_busy", busy, 0);
      end
    end

    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (ram[i] !== model_mem[i]) bad++;
    end
    check("ram_image_mismatches", bad, 0);
    check("ram_02_untouched", ram[8'h02], model_mem[8'h02]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_word_master.md
Name: mem_word_master

Overview:
- Initiator side of the byte-wide RAM interface (en / memwrite / adr / writedata / memdata).
- Converts one word request from the core into WORD_BYTES sequential byte accesses, one per clock.
- Returns the assembled read word, or stores the word as consecutive bytes.
- Sits between the multicycle datapath/controller and the byte-wide RAM.

Parameters:
WIDTH, 8, data width of one RAM location (byte), must match the RAM's WIDTH
RAM_ADDR_BITS, 8, RAM address width, must match the RAM's RAM_ADDR_BITS
WORD_BYTES, 4, number of RAM locations per word transfer (>=2)

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
req  in  1  request; sampled only while busy=0
we  in  1  1 = word write, 0 = word read; sampled with req
addr  in  RAM_ADDR_BITS  byte address of first location; sampled with req
wdata  in  WIDTH*WORD_BYTES  write word; sampled with req
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
rdata  out  WIDTH*WORD_BYTES  assembled read word; held until next read completes
mem_en  out  1  RAM enable
mem_write  out  1  RAM write strobe
mem_adr  out  RAM_ADDR_BITS  RAM address
mem_wdata  out  WIDTH  RAM write byte
mem_rdata  in  WIDTH  RAM read byte (RAM registers it on negedge clk)

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high, sampled on posedge clk.
- Reset values: state=IDLE, cnt=0, busy=0, done=0, rdata=0, mem_en=0, mem_write=0, mem_adr=0, mem_wdata=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: on posedge with req=1, latch we, addr, wdata into we_r, addr_r, wdata_r; set cnt=0; go to ACCESS. Otherwise stay.
- ACCESS outputs (functions of registered state):
  - mem_en=1, mem_write=we_r.
  - mem_adr = (addr_r + cnt) mod 2^RAM_ADDR_BITS; wraps silently, no alignment check.
  - mem_wdata = wdata_r[WIDTH*cnt +: WIDTH]; little-endian, byte 0 = lowest address.
- ACCESS timing per byte:
  - The RAM acts on the negedge inside the cycle; mem_rdata is valid at the following posedge.
  - At that posedge, if we_r=0, capture mem_rdata into the byte-cnt slot of a shadow register.
  - If cnt<WORD_BYTES-1: cnt++. Else go to DONE.
- DONE: done=1, mem_en=0, mem_write=0.
  - For reads, rdata is updated from the shadow register at the transition into DONE, so it is valid while done=1.
  - For writes, rdata is unchanged.
  - Next posedge: go to IDLE.
- Outside ACCESS: mem_en=0, mem_write=0, mem_adr/mem_wdata hold last values.
- Latency: req accepted at edge E0; ACCESS occupies cycles E0..E0+WORD_BYTES; done is high in the cycle after edge E0+WORD_BYTES (5 cycles after acceptance for default); back in IDLE one cycle later.
  - Max throughput: one word per WORD_BYTES+2 cycles.
- req while busy=1 (ACCESS or DONE): ignored, not queued. req held high continuously → a new transfer starts at the first IDLE edge.
- we/addr/wdata changes during busy: no effect (latched copies used).
- Reset mid-operation: next posedge forces IDLE, mem_en=0, rdata=0, done=0. No done pulse is emitted. RAM bytes already written stay written (partial word permitted).
- reset and req in the same cycle: reset wins; no transfer starts.

Test Plan:
1. RAM[0x10..0x13]=11,22,33,44; req=1, we=0, addr=0x10 for one cycle → mem_adr 10,11,12,13 on 4 consecutive cycles with mem_en=1, mem_write=0; done pulses 5 cycles after acceptance with rdata=0x44332211; busy low the cycle after.
2. Write: we=1, addr=0x20, wdata=0xDEADBEEF → mem_wdata EF,BE,AD,DE with mem_write=1 at 20..23; done pulse; rdata unchanged. Follow-up read of 0x20 → rdata=0xDEADBEEF.
3. Wrap: write 0x01020304 at addr=0xFE → bytes at FE,FF,00,01 = 04,03,02,01; read-back of 0xFE returns 0x01020304; RAM[0x02] untouched.
4. req held high for 20 cycles with addr changed to 0x30 mid-transfer → first transfer uses the original addr; second starts at the first IDLE edge using 0x30; exactly one done per transfer; no overlap of mem_en bursts.
5. Reset asserted during the 3rd byte of a write to 0x40 (wdata=0xAABBCCDD) → next cycle mem_en=0, busy=0, done never asserted, rdata=0; RAM[0x40]=DD, RAM[0x41]=CC, RAM[0x43] unchanged.
6. reset and req both high in the same cycle → stays IDLE, no mem_en; a req one cycle after reset deasserts completes normally.
